// File: rtl/fullass_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
package fullass_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
    } fa_stage_ctl_t;

    function automatic bit check_width(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/fullass_slice.sv
// Combinational CHUNK-bit ripple of full adders; also exposes the carry into the MSB.
module fullass_slice #(
    parameter int CHUNK = 8
) (
    input  logic             cin,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    always_comb begin
        logic c;
        // NOTE: blocking assignments let c ripple bit to bit within a single evaluation.
        c    = cin;
        cmsb = cin;
        sum  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) cmsb = c;
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/fullass_pipe.sv
// WIDTH-bit adder/subtractor split into STAGES registered CHUNK-bit slices with a
// collapsing valid/ready chain; operands are skewed forward, partial sums deskewed.
module fullass_pipe
    import fullass_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow
);

    localparam int CHUNK = WIDTH / STAGES;

    if (!check_width(WIDTH, STAGES)) begin : g_bad_cfg
        $error("fullass_pipe: WIDTH %0d must be a multiple of STAGES %0d", WIDTH, STAGES);
    end

    logic [WIDTH-1:0] b_eff;
    assign b_eff = in_b ^ {WIDTH{in_sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DONE = (k + 1) * CHUNK;
        localparam int REM  = WIDTH - DONE;

        fa_stage_ctl_t    ctl_q;
        logic [DONE-1:0]  sum_q;
        logic [DONE-1:0]  sum_d;
        logic             rdy;
        logic             down_ready;
        logic             up_valid;
        logic             load;
        logic [CHUNK-1:0] slice_a;
        logic [CHUNK-1:0] slice_b;
        logic [CHUNK-1:0] slice_sum;
        logic             slice_cin;
        logic             slice_cout;
        logic             slice_cmsb;

        if (k == 0) begin : g_src
            assign up_valid  = in_valid;
            assign slice_a   = in_a[CHUNK-1:0];
            assign slice_b   = b_eff[CHUNK-1:0];
            assign slice_cin = in_carry;
            assign sum_d     = slice_sum;
        end else begin : g_src
            assign up_valid  = g_stage[k-1].ctl_q.valid;
            assign slice_a   = g_stage[k-1].g_fwd.rem_a[CHUNK-1:0];
            assign slice_b   = g_stage[k-1].g_fwd.rem_b[CHUNK-1:0];
            assign slice_cin = g_stage[k-1].ctl_q.carry;
            assign sum_d     = {slice_sum, g_stage[k-1].sum_q};
        end

        if (k == STAGES - 1) begin : g_down
            assign down_ready = out_ready;
        end else begin : g_down
            assign down_ready = g_stage[k+1].rdy;
        end

        // An empty stage always accepts, so bubbles collapse under a stalled output.
        assign rdy  = !ctl_q.valid || down_ready;
        assign load = up_valid && rdy;

        fullass_slice #(.CHUNK(CHUNK)) u_slice (
            .cin  (slice_cin),
            .a    (slice_a),
            .b    (slice_b),
            .sum  (slice_sum),
            .cout (slice_cout),
            .cmsb (slice_cmsb)
        );

        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctl_q <= '0;
            end else if (rdy) begin
                ctl_q.valid <= up_valid;
                if (up_valid) ctl_q.carry <= slice_cout;
            end
        end

        if (k == STAGES - 1) begin : g_out
            logic ovf_q;
            // NOTE: only the visible output registers reset; inner data is qualified by valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q <= '0;
                    ovf_q <= 1'b0;
                end else if (load) begin
                    sum_q <= sum_d;
                    ovf_q <= slice_cmsb ^ slice_cout;
                end
            end
        end else begin : g_fwd
            logic [REM-1:0] rem_a;
            logic [REM-1:0] rem_b;
            logic [REM-1:0] rem_a_d;
            logic [REM-1:0] rem_b_d;
            logic           cmsb_unused;

            assign cmsb_unused = slice_cmsb;

            if (k == 0) begin : g_rem
                assign rem_a_d = in_a[WIDTH-1:CHUNK];
                assign rem_b_d = b_eff[WIDTH-1:CHUNK];
            end else begin : g_rem
                assign rem_a_d = g_stage[k-1].g_fwd.rem_a[REM+CHUNK-1:CHUNK];
                assign rem_b_d = g_stage[k-1].g_fwd.rem_b[REM+CHUNK-1:CHUNK];
            end

            always_ff @(posedge clk) begin
                if (load) begin
                    sum_q <= sum_d;
                    rem_a <= rem_a_d;
                    rem_b <= rem_b_d;
                end
            end
        end
    end

    assign in_ready     = g_stage[0].rdy;
    assign out_valid    = g_stage[STAGES-1].ctl_q.valid;
    assign out_carry    = g_stage[STAGES-1].ctl_q.carry;
    assign out_sum      = g_stage[STAGES-1].sum_q;
    assign out_overflow = g_stage[STAGES-1].g_out.ovf_q;

endmodule

// File: tb/tb_fullass_pipe.sv
// Self-checking bench for fullass_pipe: directed corner cases, backpressure, async reset,
// and a randomized run against an arithmetic reference model with an in-order scoreboard.
module tb_fullass_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int N_RAND = 2000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_overflow;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
        int               t;
    } exp_t;

    exp_t             q[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               n_fired = 0;
    logic             last_valid;
    logic             last_carry;
    logic             last_ovf;
    logic             last_in_fire;
    logic             last_in_ready;
    logic [WIDTH-1:0] last_sum;

    always #5 clk = ~clk;

    fullass_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .in_carry     (in_carry),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_carry    (out_carry),
        .out_overflow (out_overflow)
    );

    // Reference: plain unsigned and signed integer arithmetic on the operands.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sub, input logic cin, input int t);
        exp_t           e;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0] full;
        longint         sa, sb, s, smax, smin;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
        sa   = $signed(a);
        sb   = $signed(bb);
        s    = sa + sb + longint'(cin);
        smax = (longint'(1) <<< (WIDTH - 1)) - 1;
        smin = -(longint'(1) <<< (WIDTH - 1));
        e.sum   = full[WIDTH-1:0];
        e.carry = full[WIDTH];
        e.ovf   = (s > smax) || (s < smin);
        e.t     = t;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] pick();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(WIDTH-1){1'b0}}};
            3:       v = {1'b0, {(WIDTH-1){1'b1}}};
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score outputs, record input transfer, step past posedge.
    task automatic cycle();
        logic exp_v;
        @(negedge clk);
        check("in_ready", in_ready, (q.size() == STAGES && !out_ready) ? 64'd0 : 64'd1);
        exp_v = (q.size() > 0) && (cyc >= q[0].t + STAGES);
        check("out_valid", out_valid, exp_v);
        if (out_valid && q.size() > 0) begin
            check("out_sum", out_sum, q[0].sum);
            check("out_carry", out_carry, q[0].carry);
            check("out_overflow", out_overflow, q[0].ovf);
            if (out_ready) void'(q.pop_front());
        end
        last_in_ready = in_ready;
        last_in_fire  = in_valid && in_ready;
        if (last_in_fire) begin
            q.push_back(model(in_a, in_b, in_sub, in_carry, cyc));
            n_fired++;
        end
        last_valid = out_valid;
        last_sum   = out_sum;
        last_carry = out_carry;
        last_ovf   = out_overflow;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sub, input logic cin,
                            input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int lat;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_carry  = cin;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        check({tag, "_accept"}, last_in_fire, 1);
        in_valid = 1'b0;
        lat = 0;
        do begin
            cycle();
            lat++;
        end while (!last_valid && lat < 3 * STAGES);
        check({tag, "_latency"}, lat, STAGES);
        check({tag, "_sum"}, last_sum, es);
        check({tag, "_carry"}, last_carry, ec);
        check({tag, "_ovf"}, last_ovf, eo);
    endtask

    initial begin
        logic [WIDTH-1:0] bp_a[8];
        logic [WIDTH-1:0] bp_b[8];
        logic             bp_s[8];
        logic             bp_c[8];
        int               idx;
        int               offered;
        int               start;
        bit               saw_block;

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_sub       = 1'b0;
        in_carry     = 1'b0;
        out_ready    = 1'b0;
        last_in_fire = 1'b0;

        // Reset state, during assertion and in the first cycle after release.
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_carry", out_carry, 0);
        check("rst_out_ovf", out_overflow, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);
        check("rel_out_sum", out_sum, 0);
        @(posedge clk);
        #1;

        // Wrap, subtract with signed overflow, add with carry-in overflow.
        directed("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed("add_ovf", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Backpressure: 8 back-to-back beats with the output stalled for cycles 5..9.
        for (int i = 0; i < 8; i++) begin
            bp_a[i] = pick();
            bp_b[i] = pick();
            bp_s[i] = 1'($urandom_range(0, 1));
            bp_c[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        saw_block = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (idx == 8 && q.size() == 0) break;
            in_valid = (idx < 8);
            if (idx < 8) begin
                in_a     = bp_a[idx];
                in_b     = bp_b[idx];
                in_sub   = bp_s[idx];
                in_carry = bp_c[idx];
            end
            out_ready = !(c >= 5 && c <= 9);
            cycle();
            if (in_valid && !last_in_ready) saw_block = 1'b1;
            if (last_in_fire) idx++;
        end
        in_valid = 1'b0;
        check("bp_all_in", idx, 8);
        check("bp_drained", q.size(), 0);
        check("bp_in_ready_drop", saw_block, 1);

        // Async reset with beats in flight and one waiting at the output.
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 3 + STAGES; c++) begin
            in_valid = (idx < 3);
            if (idx < 3) begin
                in_a     = pick();
                in_b     = pick();
                in_sub   = 1'($urandom_range(0, 1));
                in_carry = 1'($urandom_range(0, 1));
            end
            cycle();
            if (last_in_fire) idx++;
        end
        in_valid = 1'b0;
        check("arst_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_sum", out_sum, 0);
        check("arst_out_carry", out_carry, 0);
        check("arst_out_ovf", out_overflow, 0);
        check("arst_in_ready", in_ready, 1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        directed("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        // Randomized traffic with random backpressure.
        start        = n_fired;
        offered      = 0;
        last_in_fire = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (n_fired - start == N_RAND && q.size() == 0) break;
            if (in_valid && !last_in_fire) begin
                in_valid = 1'b1;
            end else if (offered < N_RAND && $urandom_range(0, 9) < 7) begin
                in_a     = pick();
                in_b     = pick();
                in_sub   = 1'($urandom_range(0, 1));
                in_carry = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                offered++;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid = 1'b0;
        check("rand_all_in", n_fired - start, N_RAND);
        check("rand_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
